// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and widths for the sync generator and pixel generators.
package vga_timing_pkg;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned COLOR_W = 12;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COLOR_W-1:0] rgb_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle: coordinates, qualifiers and strobes from the sync generator to pixel logic.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    coord_t pixel_x;
    coord_t pixel_y;
    logic   video_on;
    logic   hsync;
    logic   vsync;
    logic   p_tick;
    logic   frame_start;

    modport master (
        output pixel_x, pixel_y, video_on, hsync, vsync, p_tick, frame_start
    );

    modport slave (
        input pixel_x, pixel_y, video_on, hsync, vsync, p_tick, frame_start
    );

endinterface

// File: rtl/pixel_tick_div.sv
// Divides the system clock down to the pixel rate; p_tick marks the last clock of each pixel.
module pixel_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("pixel_tick_div: CLK_DIV must be in 1..16");
    end

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Decoded straight from the register so CLK_DIV=1 gives a constant tick.
    assign p_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync, video and frame-start decodes.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
    parameter int unsigned H_FP        = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP        = vga_timing_pkg::H_BP,
    parameter int unsigned V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
    parameter int unsigned V_FP        = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP        = vga_timing_pkg::V_BP,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input logic            clk,
    input logic            reset,
    vga_sync_gen_if.master sig
);
    import vga_timing_pkg::*;

    localparam int unsigned H_TOT = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST    = COORD_W'(H_TOT - 1);
    localparam coord_t V_LAST    = COORD_W'(V_TOT - 1);
    localparam coord_t H_ACT     = COORD_W'(H_DISPLAY);
    localparam coord_t V_ACT     = COORD_W'(V_DISPLAY);
    localparam coord_t H_SYNC_LO = COORD_W'(H_DISPLAY + H_FP);
    localparam coord_t H_SYNC_HI = COORD_W'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam coord_t V_SYNC_LO = COORD_W'(V_DISPLAY + V_FP);
    localparam coord_t V_SYNC_HI = COORD_W'(V_DISPLAY + V_FP + V_SYNC - 1);

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic   p_tick;
    coord_t h_cnt;
    coord_t v_cnt;
    coord_t h_next;
    coord_t v_next;
    logic   frame_wrap;
    logic   hsync_q;
    logic   vsync_q;
    logic   video_on_q;
    logic   frame_start_q;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    // Next raster position; decodes below use it so they line up with the counters.
    always_comb begin
        h_next     = h_cnt;
        v_next     = v_cnt;
        frame_wrap = 1'b0;
        if (p_tick) begin
            if (h_cnt == H_LAST) begin
                h_next = '0;
                if (v_cnt == V_LAST) begin
                    v_next     = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_next = v_cnt + 1'b1;
                end
            end else begin
                h_next = h_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            video_on_q    <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt         <= h_next;
            v_cnt         <= v_next;
            hsync_q       <= (h_next >= H_SYNC_LO && h_next <= H_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_q       <= (v_next >= V_SYNC_LO && v_next <= V_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            video_on_q    <= (h_next < H_ACT) && (v_next < V_ACT);
            frame_start_q <= frame_wrap;
        end
    end

    assign sig.pixel_x     = h_cnt;
    assign sig.pixel_y     = v_cnt;
    assign sig.video_on    = video_on_q;
    assign sig.hsync       = hsync_q;
    assign sig.vsync       = vsync_q;
    assign sig.p_tick      = p_tick;
    assign sig.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three configurations checked every clock against an elapsed-time raster model.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       video_on;
        logic       hsync;
        logic       vsync;
        logic       p_tick;
        logic       frame_start;
    } obs_t;

    typedef struct packed {
        int d;
        int hd; int hf; int hs; int hb;
        int vd; int vf; int vs; int vb;
        int act;
    } cfg_t;

    localparam cfg_t CFG_A = '{d:4, hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33, act:0};
    localparam cfg_t CFG_B = '{d:2, hd:16,  hf:2,  hs:3,  hb:3,  vd:8,   vf:2,  vs:2, vb:2,  act:0};
    localparam cfg_t CFG_C = '{d:1, hd:8,   hf:1,  hs:2,  hb:1,  vd:4,   vf:1,  vs:1, vb:1,  act:1};

    logic clk = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    logic reset_c = 1'b1;
    bit   run = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // Clocks elapsed since the last edge that sampled reset high.
    int n_a = 0;
    int n_b = 0;
    int n_c = 0;

    int fs_b[$];
    int fs_c[$];
    int vs_low_b = 0;
    int hs_high_c = 0;
    int pt_low_c = 0;

    always #5 clk = ~clk;

    vga_sync_gen_if if_a ();
    vga_sync_gen_if if_b ();
    vga_sync_gen_if if_c ();

    vga_sync_gen #(
        .CLK_DIV(CFG_A.d), .H_DISPLAY(CFG_A.hd), .H_FP(CFG_A.hf), .H_SYNC(CFG_A.hs), .H_BP(CFG_A.hb),
        .V_DISPLAY(CFG_A.vd), .V_FP(CFG_A.vf), .V_SYNC(CFG_A.vs), .V_BP(CFG_A.vb), .SYNC_ACTIVE(1'b0)
    ) dut_a (.clk(clk), .reset(reset_a), .sig(if_a));

    vga_sync_gen #(
        .CLK_DIV(CFG_B.d), .H_DISPLAY(CFG_B.hd), .H_FP(CFG_B.hf), .H_SYNC(CFG_B.hs), .H_BP(CFG_B.hb),
        .V_DISPLAY(CFG_B.vd), .V_FP(CFG_B.vf), .V_SYNC(CFG_B.vs), .V_BP(CFG_B.vb), .SYNC_ACTIVE(1'b0)
    ) dut_b (.clk(clk), .reset(reset_b), .sig(if_b));

    vga_sync_gen #(
        .CLK_DIV(CFG_C.d), .H_DISPLAY(CFG_C.hd), .H_FP(CFG_C.hf), .H_SYNC(CFG_C.hs), .H_BP(CFG_C.hb),
        .V_DISPLAY(CFG_C.vd), .V_FP(CFG_C.vf), .V_SYNC(CFG_C.vs), .V_BP(CFG_C.vb), .SYNC_ACTIVE(1'b1)
    ) dut_c (.clk(clk), .reset(reset_c), .sig(if_c));

    obs_t obs_a, obs_b, obs_c;
    assign obs_a = {if_a.pixel_x, if_a.pixel_y, if_a.video_on, if_a.hsync, if_a.vsync, if_a.p_tick, if_a.frame_start};
    assign obs_b = {if_b.pixel_x, if_b.pixel_y, if_b.video_on, if_b.hsync, if_b.vsync, if_b.p_tick, if_b.frame_start};
    assign obs_c = {if_c.pixel_x, if_c.pixel_y, if_c.video_on, if_c.hsync, if_c.vsync, if_c.p_tick, if_c.frame_start};

    // Outputs after n clocks of free running: n/d whole pixels have elapsed since (0,0).
    function automatic obs_t model(int n, cfg_t c);
        int ht, vt, p, h, v;
        obs_t o;
        ht = c.hd + c.hf + c.hs + c.hb;
        vt = c.vd + c.vf + c.vs + c.vb;
        p  = n / c.d;
        h  = p % ht;
        v  = (p / ht) % vt;
        o.x           = 10'(h);
        o.y           = 10'(v);
        o.video_on    = (h < c.hd) && (v < c.vd);
        o.hsync       = (h >= c.hd + c.hf && h < c.hd + c.hf + c.hs) ? (c.act != 0) : (c.act == 0);
        o.vsync       = (v >= c.vd + c.vf && v < c.vd + c.vf + c.vs) ? (c.act != 0) : (c.act == 0);
        o.p_tick      = (n % c.d) == (c.d - 1);
        o.frame_start = (n % c.d == 0) && (p > 0) && (p % (ht * vt) == 0);
        return o;
    endfunction

    task automatic cmp_obs(string nm, int n, obs_t got, obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s n=%0d: got x=%0d y=%0d vo=%b hs=%b vs=%b pt=%b fs=%b, expected x=%0d y=%0d vo=%b hs=%b vs=%b pt=%b fs=%b",
                     nm, n, got.x, got.y, got.video_on, got.hsync, got.vsync, got.p_tick, got.frame_start,
                     exp.x, exp.y, exp.video_on, exp.hsync, exp.vsync, exp.p_tick, exp.frame_start);
        end
    endtask

    task automatic check_val(string nm, logic [31:0] got, int exp);
        vectors++;
        if (got !== 32'(exp)) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    always @(posedge clk) begin
        n_a <= reset_a ? 0 : n_a + 1;
        n_b <= reset_b ? 0 : n_b + 1;
        n_c <= reset_c ? 0 : n_c + 1;
    end

    // Every-cycle comparison against the model plus literal pins on B and C.
    always @(negedge clk) begin
        if (run) begin
            cmp_obs("A", n_a, obs_a, model(n_a, CFG_A));
            cmp_obs("B", n_b, obs_b, model(n_b, CFG_B));
            cmp_obs("C", n_c, obs_c, model(n_c, CFG_C));

            if (if_b.frame_start === 1'b1) fs_b.push_back(n_b);
            if (if_c.frame_start === 1'b1) fs_c.push_back(n_c);
            if (n_b >= 1 && n_b < 673 && if_b.vsync === 1'b0) vs_low_b++;
            if (n_c >= 1 && n_c < 85 && if_c.hsync === 1'b1) hs_high_c++;
            if (n_c >= 1 && if_c.p_tick !== 1'b1) pt_low_c++;

            case (n_b)
                366: begin
                    check_val("B (15,7) x", if_b.pixel_x, 15);
                    check_val("B (15,7) y", if_b.pixel_y, 7);
                    check_val("B (15,7) video_on", if_b.video_on, 1);
                end
                368: check_val("B (16,7) video_on", if_b.video_on, 0);
                384: begin
                    check_val("B (0,8) x", if_b.pixel_x, 0);
                    check_val("B (0,8) y", if_b.pixel_y, 8);
                    check_val("B (0,8) video_on", if_b.video_on, 0);
                end
                670: begin
                    check_val("B last x", if_b.pixel_x, 23);
                    check_val("B last y", if_b.pixel_y, 13);
                    check_val("B last video_on", if_b.video_on, 0);
                    check_val("B last p_tick early", if_b.p_tick, 0);
                end
                671: begin
                    check_val("B last p_tick", if_b.p_tick, 1);
                    check_val("B last frame_start", if_b.frame_start, 0);
                end
                672: begin
                    check_val("B wrap x", if_b.pixel_x, 0);
                    check_val("B wrap y", if_b.pixel_y, 0);
                    check_val("B wrap frame_start", if_b.frame_start, 1);
                end
                673: check_val("B frame_start width", if_b.frame_start, 0);
                default: ;
            endcase

            case (n_c)
                8:  check_val("C x8 hsync", if_c.hsync, 0);
                9:  check_val("C x9 hsync", if_c.hsync, 1);
                11: begin
                    check_val("C end of line x", if_c.pixel_x, 11);
                    check_val("C end of line y", if_c.pixel_y, 0);
                end
                12: begin
                    check_val("C line wrap x", if_c.pixel_x, 0);
                    check_val("C line wrap y", if_c.pixel_y, 1);
                end
                84: begin
                    check_val("C frame wrap y", if_c.pixel_y, 0);
                    check_val("C frame_start", if_c.frame_start, 1);
                end
                default: ;
            endcase
        end
    end

    task automatic reset_checks(string tag);
        check_val({tag, " reset x"}, if_a.pixel_x, 0);
        check_val({tag, " reset y"}, if_a.pixel_y, 0);
        check_val({tag, " reset hsync"}, if_a.hsync, 1);
        check_val({tag, " reset vsync"}, if_a.vsync, 1);
        check_val({tag, " reset video_on"}, if_a.video_on, 1);
        check_val({tag, " reset frame_start"}, if_a.frame_start, 0);
        check_val({tag, " reset p_tick"}, if_a.p_tick, 0);
    endtask

    // After release: p_tick first high on the 4th clock, x steps to 1 on the next.
    task automatic release_checks(string tag);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_val($sformatf("%s release k=%0d p_tick", tag, k), if_a.p_tick, (k == 3) ? 1 : 0);
            check_val($sformatf("%s release k=%0d x", tag, k), if_a.pixel_x, (k == 4) ? 1 : 0);
        end
    endtask

    initial begin
        int hs_low_a;
        int y_chg[$];
        logic [9:0] prev_y;

        @(posedge clk);
        #1 run = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_a = 1'b0;
        reset_b = 1'b0;
        reset_c = 1'b0;
        reset_checks("A");
        release_checks("A");

        hs_low_a = 0;
        prev_y = if_a.pixel_y;
        while (n_a < 6400) begin
            @(negedge clk);
            if (n_a < 3200 && if_a.hsync === 1'b0) hs_low_a++;
            if (if_a.pixel_y !== prev_y) y_chg.push_back(n_a);
            prev_y = if_a.pixel_y;
            if (n_a == 2559) begin
                check_val("A x639 x", if_a.pixel_x, 639);
                check_val("A x639 video_on", if_a.video_on, 1);
            end
            if (n_a == 2560) begin
                check_val("A x640 x", if_a.pixel_x, 640);
                check_val("A x640 video_on", if_a.video_on, 0);
            end
            if (n_a == 3199) begin
                check_val("A x799 x", if_a.pixel_x, 799);
                check_val("A x799 y", if_a.pixel_y, 0);
            end
            if (n_a == 3200) begin
                check_val("A line wrap x", if_a.pixel_x, 0);
                check_val("A line wrap y", if_a.pixel_y, 1);
            end
        end
        check_val("A hsync low clks per line", hs_low_a, 384);
        check_val("A y changes in two lines", y_chg.size(), 2);
        if (y_chg.size() >= 2) check_val("A line period", y_chg[1] - y_chg[0], 3200);

        // Mid-pixel reset at x=300 with the divider at 2.
        while (n_a < 7602) @(negedge clk);
        check_val("A pre-reset x", if_a.pixel_x, 300);
        check_val("A pre-reset y", if_a.pixel_y, 2);
        reset_a = 1'b1;
        @(negedge clk);
        reset_checks("A mid");
        reset_a = 1'b0;
        release_checks("A mid");

        repeat (200) @(negedge clk);

        check_val("B vsync low clks per frame", vs_low_b, 96);
        check_val("B frame_start count", fs_b.size(), n_b / 672);
        foreach (fs_b[i]) check_val($sformatf("B frame_start %0d at", i), fs_b[i], 672 * (i + 1));
        check_val("C hsync high clks per frame", hs_high_c, 14);
        check_val("C p_tick low clks", pt_low_c, 0);
        check_val("C frame_start count", fs_c.size(), n_c / 84);
        foreach (fs_c[i]) check_val($sformatf("C frame_start %0d at", i), fs_c[i], 84 * (i + 1));

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Timing generator for a 640x480 @ ~60 Hz VGA raster, running from the 100 MHz system clock.
- Produces pixel coordinates, the active-video qualifier and the sync pulses consumed by the pixel/animation generators, which supply RGB back.
- A pixel-enable tick divides the system clock down to the 25 MHz pixel rate.
- Emits a one-clock frame-start strobe, so downstream logic can update once per frame instead of using free-running 60 Hz counters.

Parameters:
CLK_DIV, 4, system clocks per pixel (1..16)
H_DISPLAY, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_DISPLAY, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high reset
pixel_x  out  10  current column, 0..H_TOTAL-1
pixel_y  out  10  current row, 0..V_TOTAL-1
video_on  out  1  high when pixel_x<H_DISPLAY and pixel_y<V_DISPLAY
hsync  out  1  horizontal sync, level per SYNC_ACTIVE
vsync  out  1  vertical sync, level per SYNC_ACTIVE
p_tick  out  1  one-clk pulse; the raster advances at the end of this cycle
frame_start  out  1  one-clk pulse on the first clk at (0,0) after a wrap

Behaviour:
Clock and reset:
- One clock, clk. Reset is synchronous and active-high; all state updates on the rising edge of clk.

Derived constants:
- H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP = 800.
- V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP = 525.
- Both must be <= 1024; elaboration fails otherwise.

Divider:
- div_cnt counts 0..CLK_DIV-1 and wraps.
- p_tick = (div_cnt==CLK_DIV-1), decoded directly from the register.
- With CLK_DIV=1, p_tick is constantly 1 after reset.

Raster counters (update only on clocks where p_tick=1):
- h_cnt==H_TOTAL-1: h_cnt<=0, else h_cnt+1.
- v_cnt advances only when h_cnt wraps.
- v_cnt==V_TOTAL-1 at that point: v_cnt<=0, else v_cnt+1.
- pixel_x=h_cnt and pixel_y=v_cnt, direct register outputs.

Registered decodes (computed from the next-state counter values, so zero skew against pixel_x/pixel_y):
- hsync asserted for h in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1] = [656,751].
- vsync asserted for v in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC-1] = [490,491].
- video_on = (h<640)&&(v<480).
- frame_start <= 1 on the p_tick clock where both counters wrap, else 0.

Reset values:
- div_cnt=0, h_cnt=0, v_cnt=0, p_tick=0 (unless CLK_DIV=1).
- hsync=vsync=~SYNC_ACTIVE, video_on=1, frame_start=0.
- Releasing reset does not generate frame_start; the first pulse follows the first full frame.

Reset mid-operation:
- Any state returns to the reset values on the next edge; no partial line or frame continues.

Timing consequences:
- Line = H_TOTAL*CLK_DIV = 3200 clks; frame = 1,680,000 clks (59.52 Hz).
- Each coordinate is held CLK_DIV clks.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the H/V display, porch and sync constants;
  - derived H_TOTAL and V_TOTAL;
  - coordinate width (10);
  - the colour width (12).
- The pixel generators import the same package for screen bounds (640, 480).
- One natural sub-module: pixel_tick_div (parameter CLK_DIV; ports clk, reset, p_tick).
- Counters and sync decode stay in vga_sync_gen.

Test Plan:
1. Reset held 3 clks then released -> x=0, y=0, hsync=vsync=1, video_on=1, frame_start=0; p_tick first high on 4th clk after release; x=1 on the following clk.
2. Run one line -> video_on falls with x 639->640; hsync low exactly for x=656..751 (384 clks); x 799->0 coincides with y 0->1; line period 3200 clks.
3. Run two frames -> vsync low for y=490..491 (6400 clks); frame_start pulses exactly once per 1,680,000 clks, each pulse 1 clk wide, aligned with x=0, y=0.
4. Assert reset 1 clk at x=300, y=200 mid-pixel (div_cnt=2) -> next clk x=0, y=0, div_cnt=0, no frame_start; the sequence then matches scenario 1.
5. Boundaries -> (639,479) video_on=1; (640,479), (0,480) and (799,524) video_on=0; (799,524)->(0,0) on the next p_tick with frame_start=1.
6. Override CLK_DIV=1, H=8/1/2/1, V=4/1/1/1, SYNC_ACTIVE=1 -> p_tick constant 1; hsync high for x=9..10; line 12 clks; frame 84 clks.
